// File: rtl/and_or_pkg.sv
// ============================================================================
// Module      : and_or_pkg
// Description : Operator encoding and the shared bitwise evaluation function
//               for the and_or_pipe datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package and_or_pkg;

    // Widest operand the evaluation function handles; callers zero-extend.
    localparam int c_MAX_W = 64;

    typedef enum logic [1:0] {
        OP_AND_OR   = 2'd0,
        OP_NAND_NOR = 2'd1,
        OP_XOR      = 2'd2,
        OP_PASS     = 2'd3
    } op_e;

    // Returns {x, y}, each c_MAX_W bits wide.
    function automatic logic [2*c_MAX_W-1:0] and_or_eval(
        input op_e                op,
        input logic [c_MAX_W-1:0] a,
        input logic [c_MAX_W-1:0] b,
        input logic [c_MAX_W-1:0] c
    );
        logic [c_MAX_W-1:0] x;
        logic [c_MAX_W-1:0] y;
        case (op)
            OP_AND_OR: begin
                x = a & b;
                y = b | c;
            end
            OP_NAND_NOR: begin
                x = ~(a & b);
                y = ~(b | c);
            end
            OP_XOR: begin
                x = a ^ b;
                y = b ^ c;
            end
            default: begin
                x = a;
                y = c;
            end
        endcase
        return {x, y};
    endfunction

endpackage

`default_nettype wire

// File: rtl/and_or_stage.sv
// ============================================================================
// Module      : and_or_stage
// Description : One pipeline register stage carrying valid, x, y and op,
//               with load enable and synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_or_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [1:0]       i_op,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic [1:0]       o_op
);

    logic             r_valid_q;
    logic [WIDTH-1:0] r_x_q;
    logic [WIDTH-1:0] r_y_q;
    logic [1:0]       r_op_q;

    logic             w_valid_d;
    logic [WIDTH-1:0] w_x_d;
    logic [WIDTH-1:0] w_y_d;
    logic [1:0]       w_op_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_x_d     = r_x_q;
        w_y_d     = r_y_q;
        w_op_d    = r_op_q;
        if (i_en) begin
            w_valid_d = i_valid;
            w_x_d     = i_x;
            w_y_d     = i_y;
            w_op_d    = i_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_x_q     <= '0;
            r_y_q     <= '0;
            r_op_q    <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_x_q     <= w_x_d;
            r_y_q     <= w_y_d;
            r_op_q    <= w_op_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_x     = r_x_q;
    assign o_y     = r_y_q;
    assign o_op    = r_op_q;

endmodule

`default_nettype wire

// File: rtl/and_or_pipe.sv
// ============================================================================
// Module      : and_or_pipe
// Description : Valid/ready pipelined AND/OR-family operator unit with a
//               global-stall pipeline and a saturating transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module and_or_pipe
    import and_or_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       out_op,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic                  w_advance;
    logic [c_MAX_W-1:0]    w_a_ext;
    logic [c_MAX_W-1:0]    w_b_ext;
    logic [c_MAX_W-1:0]    w_c_ext;
    logic [2*c_MAX_W-1:0]  w_res;
    logic                  w_unused;

    // Index 0 is the freshly computed result; index i+1 is stage i's output.
    logic                  w_vld [LATENCY+1];
    logic [WIDTH-1:0]      w_x   [LATENCY+1];
    logic [WIDTH-1:0]      w_y   [LATENCY+1];
    logic [1:0]            w_op  [LATENCY+1];

    logic [CNT_W-1:0]      r_cnt_q;
    logic [CNT_W-1:0]      w_cnt_d;

    // A full output stage that is not being drained freezes the whole pipe.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance && !rst;

    always_comb begin
        w_a_ext              = '0;
        w_b_ext              = '0;
        w_c_ext              = '0;
        w_a_ext[WIDTH-1:0]   = a;
        w_b_ext[WIDTH-1:0]   = b;
        w_c_ext[WIDTH-1:0]   = c;
        w_res                = and_or_eval(op_e'(op), w_a_ext, w_b_ext, w_c_ext);
    end

    assign w_unused = ^w_res;

    assign w_vld[0] = in_valid;
    assign w_x[0]   = w_res[c_MAX_W +: WIDTH];
    assign w_y[0]   = w_res[0 +: WIDTH];
    assign w_op[0]  = op;

    generate
        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            and_or_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_advance),
                .i_valid (w_vld[i]),
                .i_x     (w_x[i]),
                .i_y     (w_y[i]),
                .i_op    (w_op[i]),
                .o_valid (w_vld[i+1]),
                .o_x     (w_x[i+1]),
                .o_y     (w_y[i+1]),
                .o_op    (w_op[i+1])
            );
        end
    endgenerate

    assign out_valid = w_vld[LATENCY];
    assign x         = w_x[LATENCY];
    assign y         = w_y[LATENCY];
    assign out_op    = w_op[LATENCY];

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (out_valid && out_ready && (r_cnt_q != c_CNT_MAX)) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign xfer_cnt = r_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_and_or_pipe.sv
// ============================================================================
// Module      : tb_and_or_pipe
// Description : Directed and random checks of and_or_pipe across several
//               parameterisations sharing one clock, reset and operand bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_and_or_pipe;
    import and_or_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] a, b, c;
    logic [1:0] op;

    // m_: WIDTH=8 LATENCY=2 CNT_W=16, s_: CNT_W=2, t_: LATENCY=3, p_: LATENCY=1
    logic m_iv, m_ir, m_ov, m_or;  logic [7:0] m_x, m_y;  logic [1:0] m_op;  logic [15:0] m_cnt;
    logic s_iv, s_ir, s_ov, s_or;  logic [7:0] s_x, s_y;  logic [1:0] s_op;  logic [1:0]  s_cnt;
    logic t_iv, t_ir, t_ov, t_or;  logic [7:0] t_x, t_y;  logic [1:0] t_op;  logic [15:0] t_cnt;
    logic p_iv, p_ir, p_ov, p_or;  logic [7:0] p_x, p_y;  logic [1:0] p_op;  logic [15:0] p_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    and_or_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .a(a), .b(b), .c(c), .op(op),
        .out_valid(m_ov), .out_ready(m_or), .x(m_x), .y(m_y), .out_op(m_op), .xfer_cnt(m_cnt));
    and_or_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .a(a), .b(b), .c(c), .op(op),
        .out_valid(s_ov), .out_ready(s_or), .x(s_x), .y(s_y), .out_op(s_op), .xfer_cnt(s_cnt));
    and_or_pipe #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .in_valid(t_iv), .in_ready(t_ir), .a(a), .b(b), .c(c), .op(op),
        .out_valid(t_ov), .out_ready(t_or), .x(t_x), .y(t_y), .out_op(t_op), .xfer_cnt(t_cnt));
    and_or_pipe #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .in_valid(p_iv), .in_ready(p_ir), .a(a), .b(b), .c(c), .op(op),
        .out_valid(p_ov), .out_ready(p_or), .x(p_x), .y(p_y), .out_op(p_op), .xfer_cnt(p_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        m_iv = 1'b0; s_iv = 1'b0; t_iv = 1'b0; p_iv = 1'b0;
        m_or = 1'b1; s_or = 1'b1; t_or = 1'b1; p_or = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] ex_x [4]   = '{8'h30, 8'hCF, 8'hCC, 8'hF0};
    logic [7:0] ex_y [4]   = '{8'h3F, 8'hC0, 8'h33, 8'h0F};
    logic [7:0] bp_x [4]   = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    logic [17:0] sb_q [$];

    initial begin
        int sent, rcv, seen, n_hs;
        logic [127:0] r;
        logic [17:0]  item;

        // Reset state and basic latency / all-mode ordering
        a = 8'hF0; b = 8'h3C; c = 8'h0F; op = 2'd0;
        rst = 1'b1;
        m_iv = 1'b0; s_iv = 1'b0; t_iv = 1'b0; p_iv = 1'b0;
        m_or = 1'b1; s_or = 1'b1; t_or = 1'b1; p_or = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(m_ir), 64'h0);
        chk("rst_out_valid", 64'(m_ov), 64'h0);
        chk("rst_xy_op", 64'({m_x, m_y, m_op}), 64'h0);
        chk("rst_cnt", 64'(m_cnt), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(m_ir), 64'h1);

        for (int i = 0; i < 4; i++) begin
            op   = 2'(i);
            m_iv = 1'b1;
            step();
            if (i == 0) begin
                chk("lat_not_yet", 64'(m_ov), 64'h0);
            end else begin
                chk("mode_valid", 64'(m_ov), 64'h1);
                chk("mode_result", 64'({m_op, m_x, m_y}), 64'({2'(i - 1), ex_x[i-1], ex_y[i-1]}));
                chk("mode_cnt", 64'(m_cnt), 64'(i - 1));
            end
        end
        m_iv = 1'b0;
        step();
        chk("mode_last", 64'({m_ov, m_op, m_x, m_y}), 64'({1'b1, 2'd3, ex_x[3], ex_y[3]}));
        step();
        chk("mode_drained", 64'(m_ov), 64'h0);
        chk("mode_cnt_final", 64'(m_cnt), 64'd4);

        // Backpressure: out_ready low for cycles 2..4 while the first result waits
        do_reset();
        sent = 0; rcv = 0;
        b = 8'hFF; c = 8'h00; op = 2'd2;
        for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
            m_iv = (sent < 4);
            a    = 8'(8'h11 * (sent + 1));
            m_or = !(cyc >= 2 && cyc < 5);
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("bp_stall_valid", 64'(m_ov), 64'h1);
                chk("bp_in_ready", 64'(m_ir), 64'h0);
                chk("bp_hold", 64'({m_x, m_y}), 64'({bp_x[rcv], 8'hFF}));
            end
            if (m_ov && m_or) begin
                chk("bp_out", 64'({m_op, m_x, m_y}), 64'({2'd2, bp_x[rcv], 8'hFF}));
                rcv++;
            end
            if (m_iv && m_ir) sent++;
            step();
        end
        m_iv = 1'b0;
        chk("bp_rcv_count", 64'(rcv), 64'd4);
        step();
        chk("bp_no_dup", 64'(m_ov), 64'h0);
        chk("bp_cnt", 64'(m_cnt), 64'd4);

        // Counter saturation with a 2-bit counter
        do_reset();
        sent = 0; rcv = 0;
        a = 8'h12; b = 8'h34; c = 8'h56; op = 2'd0;
        for (int cyc = 0; cyc < 20 && rcv < 5; cyc++) begin
            logic hs;
            s_iv = (sent < 5);
            #1;
            hs = s_ov && s_or;
            if (s_iv && s_ir) sent++;
            step();
            if (hs) begin
                chk("sat_cnt", 64'(s_cnt), 64'(sat_exp[rcv]));
                rcv++;
            end
        end
        s_iv = 1'b0;
        chk("sat_deliveries", 64'(rcv), 64'd5);

        // Reset with three transactions in flight in the LATENCY=3 instance
        do_reset();
        t_or = 1'b0;
        a = 8'hA5; b = 8'h00; c = 8'h5A; op = 2'd3;
        for (int i = 0; i < 3; i++) begin
            t_iv = 1'b1;
            step();
        end
        t_iv = 1'b0;
        chk("mf_head_valid", 64'({t_ov, t_x, t_y}), 64'({1'b1, 8'hA5, 8'h5A}));
        rst  = 1'b1;
        t_or = 1'b1;
        #1;
        chk("mf_rst_in_ready", 64'(t_ir), 64'h0);
        step();
        rst = 1'b0;
        chk("mf_rst_valid", 64'(t_ov), 64'h0);
        chk("mf_rst_cnt", 64'(t_cnt), 64'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (t_ov) seen++;
            step();
        end
        chk("mf_never_appears", 64'(seen), 64'h0);
        chk("mf_cnt_after", 64'(t_cnt), 64'h0);

        // LATENCY=1 random soak against the reference evaluation
        do_reset();
        n_hs = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            p_iv = 1'($urandom_range(0, 1));
            p_or = ($urandom_range(0, 3) != 0);
            a    = 8'($urandom);
            b    = 8'($urandom);
            c    = 8'($urandom);
            op   = 2'($urandom);
            #1;
            chk("soak_in_ready", 64'(p_ir), 64'(!p_ov || p_or));
            if (p_ov && p_or) begin
                n_hs++;
                if (sb_q.size() == 0) begin
                    chk("soak_unexpected", 64'h1, 64'h0);
                end else begin
                    item = sb_q.pop_front();
                    chk("soak_out", 64'({p_op, p_x, p_y}), 64'(item));
                end
            end
            if (p_iv && p_ir) begin
                r = and_or_eval(op_e'(op), {56'b0, a}, {56'b0, b}, {56'b0, c});
                sb_q.push_back({op, r[71:64], r[7:0]});
            end
            step();
        end
        p_iv = 1'b0;
        chk("soak_cnt", 64'(p_cnt), 64'(n_hs));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
